// File: rtl/sdf_r2_bf_stage_pkg.sv
// Shared defaults and helpers for the SDF radix-2 FFT stages.
package sdf_r2_bf_stage_pkg;

  localparam int unsigned NfftDefault = 128;
  localparam int unsigned DwDefault   = 16;
  localparam int unsigned TwDefault   = 16;

  // Phase encoding matches the sel1 line from the mux control unit.
  typedef enum logic {
    PhFill = 1'b0,
    PhBfly = 1'b1
  } phase_e;

  function automatic int unsigned delay_depth(int unsigned nfft, int unsigned stage_no);
    return nfft >> stage_no;
  endfunction

endpackage

// File: rtl/sdf_r2_bf_stage_if.sv
// Sample stream into and out of one SDF butterfly stage, including twiddle and phase select.
interface sdf_r2_bf_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16
);
  logic                 in_valid;
  logic signed [DW-1:0] in_re;
  logic signed [DW-1:0] in_im;
  logic                 sel1;
  logic signed [TW-1:0] tw_re;
  logic signed [TW-1:0] tw_im;
  logic                 out_valid;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;

  modport master (
    output in_valid, in_re, in_im, sel1, tw_re, tw_im,
    input  out_valid, out_re, out_im
  );

  modport slave (
    input  in_valid, in_re, in_im, sel1, tw_re, tw_im,
    output out_valid, out_re, out_im
  );
endinterface

// File: rtl/sdf_delay_line.sv
// Circular delay buffer; one pointer serves as both read head and write address.
module sdf_delay_line #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;

  assign dout = mem_q[ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      mem_q[ptr_q] <= din;
      ptr_q        <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/sdf_r2_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: fill/twiddle phase and butterfly phase.
module sdf_r2_bf_stage
  import sdf_r2_bf_stage_pkg::*;
#(
  parameter int unsigned NFFT     = NfftDefault,
  parameter int unsigned STAGE_NO = 1,
  parameter int unsigned DW       = DwDefault,
  parameter int unsigned TW       = TwDefault
) (
  input logic              clk,
  input logic              rst,
  sdf_r2_bf_stage_if.slave bus
);
  localparam int unsigned D  = delay_depth(NFFT, STAGE_NO);
  localparam int unsigned PW = DW + TW + 1;

  localparam logic signed [PW-1:0] RndConst = PW'(1) << (TW - 2);
  localparam logic signed [PW-1:0] SatMax   = {{(PW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [PW-1:0] SatMin   = {{(PW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

  phase_e                 phase;
  logic [2*DW-1:0]        head;
  logic [2*DW-1:0]        line_din;
  logic signed [DW-1:0]   head_re, head_im;
  logic signed [DW:0]     sum_re, sum_im, dif_re, dif_im;
  logic signed [DW+TW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]   rnd_re, rnd_im;
  logic                   take;
  logic                   primed_q;
  logic                   out_valid_q;
  logic signed [DW-1:0]   out_re_q, out_im_q;
  logic                   unused_lsb;

  assign phase   = phase_e'(bus.sel1);
  assign head_re = head[2*DW-1:DW];
  assign head_im = head[DW-1:0];

  sdf_delay_line #(
    .DEPTH (D),
    .WIDTH (2 * DW)
  ) u_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.in_valid),
    .din  (line_din),
    .dout (head)
  );

  // One extra bit of headroom; dropping the LSB is the >>>1 scaling.
  assign sum_re = {head_re[DW-1], head_re} + {bus.in_re[DW-1], bus.in_re};
  assign sum_im = {head_im[DW-1], head_im} + {bus.in_im[DW-1], bus.in_im};
  assign dif_re = {head_re[DW-1], head_re} - {bus.in_re[DW-1], bus.in_re};
  assign dif_im = {head_im[DW-1], head_im} - {bus.in_im[DW-1], bus.in_im};
  assign unused_lsb = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  always_comb begin
    line_din = {bus.in_re, bus.in_im};
    if (phase == PhBfly) begin
      line_din = {dif_re[DW:1], dif_im[DW:1]};
    end
  end

  assign p_rr = (DW + TW)'(head_re) * (DW + TW)'(bus.tw_re);
  assign p_ii = (DW + TW)'(head_im) * (DW + TW)'(bus.tw_im);
  assign p_ri = (DW + TW)'(head_re) * (DW + TW)'(bus.tw_im);
  assign p_ir = (DW + TW)'(head_im) * (DW + TW)'(bus.tw_re);

  // Round half-up back to Q(DW) by adding half an LSB before the shift.
  assign rnd_re = (PW'(p_rr) - PW'(p_ii) + RndConst) >>> (TW - 1);
  assign rnd_im = (PW'(p_ri) + PW'(p_ir) + RndConst) >>> (TW - 1);

  function automatic logic [DW-1:0] sat(logic signed [PW-1:0] v);
    if (v > SatMax) return SatMax[DW-1:0];
    if (v < SatMin) return SatMin[DW-1:0];
    return v[DW-1:0];
  endfunction

  // Outputs before the first butterfly come from an unfilled delay line and are dropped.
  assign take = bus.in_valid & (primed_q | bus.sel1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      out_valid_q <= take;
      if (bus.in_valid && phase == PhBfly) begin
        primed_q <= 1'b1;
      end
      if (take) begin
        case (phase)
          PhBfly: begin
            out_re_q <= sum_re[DW:1];
            out_im_q <= sum_im[DW:1];
          end
          default: begin
            out_re_q <= sat(rnd_re);
            out_im_q <= sat(rnd_im);
          end
        endcase
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;

endmodule
